// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: arbitrates two write-back requesters onto the register file write port and scoreboards pending writes
module regs_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_addr,
  output logic                  issue_ready,
  input  logic                  a_valid,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_ready,
  output logic                  wen,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [2**ADDR_W-1:0]  busy
);
  localparam int N = 2**ADDR_W;
  logic [3:0] starve_q, starve_d;
  logic [N-1:0][1:0] cnt_q, cnt_d;
  logic wen_q;
  logic [ADDR_W-1:0] rd_addr_q, g_addr;
  logic [DATA_W-1:0] rd_data_q, g_data;
  logic b_win, gnt, issue_ok;
  // B wins when A is idle or B has been denied STARVE_MAX cycles in a row
  assign b_win = b_valid && (!a_valid || starve_q == 4'(STARVE_MAX));
  assign b_ready = !rst && b_win;
  assign a_ready = !rst && a_valid && !b_win;
  assign gnt = a_ready || b_ready;
  assign g_addr = b_ready ? b_addr : a_addr;
  assign g_data = b_ready ? b_data : a_data;
  // a full counter can still accept an issue if a write to it retires this cycle
  assign issue_ready = !rst && (cnt_q[issue_addr] != 2'd3 || (gnt && g_addr == issue_addr));
  assign issue_ok = issue_valid && issue_ready;
  assign starve_d = (!b_valid || b_ready) ? 4'd0 : (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
  assign wen = wen_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  // pending-write counters: issue increments, grant decrements (floored at 0), both together cancel; r0 never tracked
  always_comb begin
    cnt_d = cnt_q;
    busy = '0;
    for (int i = 1; i < N; i++) begin
      cnt_d[i] = (issue_ok && issue_addr == ADDR_W'(i) && gnt && g_addr == ADDR_W'(i)) ? cnt_q[i] :
                 (issue_ok && issue_addr == ADDR_W'(i)) ? cnt_q[i] + 2'd1 :
                 (gnt && g_addr == ADDR_W'(i) && cnt_q[i] != 2'd0) ? cnt_q[i] - 2'd1 : cnt_q[i];
      busy[i] = cnt_q[i] != 2'd0;
    end
  end
  // registered write stage plus scoreboard and starvation state
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      cnt_q <= '0;
      wen_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      starve_q <= starve_d;
      cnt_q <= cnt_d;
      wen_q <= gnt && g_addr != '0;
      if (gnt && g_addr != '0) begin
        rd_addr_q <= g_addr;
        rd_data_q <= g_data;
      end
    end
  end
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter: scoreboard bench with directed and random stimulus against a reference model
module tb_regs_wb_arbiter;
  localparam int DW = 16, AW = 3, SM = 3, N = 8;
  logic clk = 1'b0, rst;
  logic issue_valid, a_valid, b_valid, issue_ready, a_ready, b_ready, wen;
  logic [AW-1:0] issue_addr, a_addr, b_addr, rd_addr;
  logic [DW-1:0] a_data, b_data, rd_data;
  logic [N-1:0] busy;
  int nchk = 0, nerr = 0, cyc = 0;
  typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t q[$];
  int m_cnt[N];
  int m_starve;
  logic last_ar, last_br, last_ir, a_granted, b_granted;
  logic ra_v, rb_v, r_iv, r_rst;
  logic [AW-1:0] ra_a, rb_a, r_ia;
  logic [DW-1:0] ra_d, rb_d;
  logic [DW-1:0] nb;

  regs_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wen(wen), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic iv, input logic [AW-1:0] ia);
    logic ea, eb, ei, g, same;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic [N-1:0] ebusy;
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; issue_valid = iv; issue_addr = ia;
    #1;
    eb = !r && bv && (!av || m_starve == SM);
    ea = !r && av && !eb;
    g = ea || eb;
    ga = eb ? ba : aa;
    gd = eb ? bd : ad;
    ei = !r && (m_cnt[ia] < 3 || (g && ga == ia));
    for (int i = 0; i < N; i++) ebusy[i] = m_cnt[i] > 0;
    last_ar = a_ready; last_br = b_ready; last_ir = issue_ready;
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("issue_ready", issue_ready, ei);
    chk("busy", busy, ebusy);
    if (g && ga != 0) q.push_back('{cyc + 1, ga, gd});
    if (r) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_starve = 0;
    end else begin
      same = iv && ei && ia != 0 && g && ga == ia;
      if (iv && ei && ia != 0 && !same) m_cnt[ia]++;
      if (g && ga != 0 && !same && m_cnt[ga] > 0) m_cnt[ga]--;
      m_starve = (!bv || eb) ? 0 : (m_starve < SM ? m_starve + 1 : SM);
    end
    a_granted = ea; b_granted = eb;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    bit due;
    wr_t w;
    due = q.size() > 0 && q[0].c == cyc;
    if (wen === 1'b1 || due) begin
      if (!due) begin
        nchk++; nerr++;
        $display("FAIL wen_spurious: got write addr %0h data %0h expected none (cycle %0d)", rd_addr, rd_data, cyc);
      end else begin
        w = q.pop_front();
        chk("wen", wen, 1);
        chk("rd_addr", rd_addr, w.a);
        chk("rd_data", rd_data, w.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_starve = 0;
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 16'h5555, 1, 3, 16'h6666, 1, 2);
    chk("rst_wen", wen, 0); chk("rst_rd_addr", rd_addr, 0); chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {last_ar, last_br, last_ir}, 0);
    step(0, 1, 5, 16'h1234, 0, 0, 0, 0, 0);
    chk("a_only_ready", last_ar, 1);
    chk("a_only_wen", wen, 1); chk("a_only_addr", rd_addr, 5); chk("a_only_data", rd_data, 16'h1234);
    nb = 16'hB000;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 1, 16'(k), 1, 2, nb, 0, 0);
      chk("starve_pattern", last_ar, (k % 4) != 3);
      if (b_granted) nb = nb + 1;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    chk("busy3_set", busy[3], 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    chk("issue_full", last_ir, 0);
    step(0, 1, 3, 16'h3333, 0, 0, 0, 1, 3);
    chk("issue_bypass", last_ir, 1);
    chk("busy3_hold", busy[3], 1);
    for (int k = 0; k < 3; k++) step(0, 1, 3, 16'h3300 + 16'(k), 0, 0, 0, 0, 0);
    chk("busy3_clear", busy[3], 0);
    step(0, 0, 0, 0, 1, 0, 16'hDEAD, 0, 0);
    chk("r0_b_ready", last_br, 1);
    chk("r0_no_wen", wen, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("r0_issue_ready", last_ir, 1);
    chk("r0_busy", busy, 0);
    step(0, 1, 6, 16'h6060, 1, 7, 16'h7070, 1, 4);
    step(0, 1, 6, 16'h6061, 1, 7, 16'h7070, 1, 5);
    step(1, 1, 6, 16'h6062, 1, 7, 16'h7070, 0, 0);
    chk("rst_mid_a_ready", last_ar, 0);
    chk("rst_mid_busy", busy, 0); chk("rst_mid_wen", wen, 0);
    chk("rst_mid_addr", rd_addr, 0); chk("rst_mid_data", rd_data, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 6, 16'h6100 + 16'(k), 1, 7, 16'h7070, 0, 0);
      chk("rst_starve_restart", last_br, k == 3);
    end
    ra_v = 0; rb_v = 0; ra_a = 0; rb_a = 0; ra_d = 0; rb_d = 0;
    for (int k = 0; k < 1500; k++) begin
      if (!ra_v && $urandom_range(0, 2) != 0) begin
        ra_v = 1; ra_a = AW'($urandom_range(0, 4)); ra_d = DW'($urandom);
      end
      if (!rb_v && $urandom_range(0, 1) != 0) begin
        rb_v = 1; rb_a = AW'($urandom_range(0, 7)); rb_d = DW'($urandom);
      end
      r_iv = 1'($urandom_range(0, 1));
      r_ia = $urandom_range(0, 1) != 0 ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 7));
      r_rst = $urandom_range(0, 99) == 0;
      step(r_rst, ra_v, ra_a, ra_d, rb_v, rb_a, rb_d, r_iv, r_ia);
      if (a_granted) ra_v = 0;
      if (b_granted) rb_v = 0;
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
